// File: rtl/neopixel_frame_feeder_pkg.sv
// Shared definitions for the neopixel frame feeder: register map, transmitter map,
// colour type, FSM encoding and the bit-reversal helper.
package neopixel_frame_feeder_pkg;

    // Host slave register map
    localparam logic [7:0] CTRL       = 8'h00;
    localparam logic [7:0] BRIGHT     = 8'h01;
    localparam logic [7:0] FCOUNT     = 8'h02;
    localparam logic [7:0] PIXEL_BASE = 8'h10;

    // Transmitter register map
    localparam logic [7:0] TX_TRIGGER    = 8'h00;
    localparam logic [7:0] TX_PIXEL_BASE = 8'h01;

    localparam logic [31:0] READ_DEFAULT = 32'hDEAD_BEEF;

    typedef logic [23:0] color_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StTrigger
    } feeder_state_e;

    // The transmitter shifts bit 0 out first, so the GRB word is sent mirrored.
    function automatic logic [23:0] bitrev24(input logic [23:0] v);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) begin
            r[i] = v[23-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/neopixel_pixel_scaler.sv
// Combinational pixel path: scales each RRGGBB channel by brightness and emits the
// bit-reversed GRB word expected by the transmitter.
module neopixel_pixel_scaler
    import neopixel_frame_feeder_pkg::*;
(
    input  logic [23:0] rgb_i,
    input  logic [7:0]  bright_i,
    output logic [23:0] word_o
);

    // (c * (b + 1)) >> 8: b = 255 is identity, b = 0 blanks the channel.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'h00, c} * ({8'h00, b} + 16'd1);
        return prod[15:8];
    endfunction

    logic [7:0] red_s;
    logic [7:0] green_s;
    logic [7:0] blue_s;

    always_comb begin
        red_s   = scale(rgb_i[23:16], bright_i);
        green_s = scale(rgb_i[15:8], bright_i);
        blue_s  = scale(rgb_i[7:0], bright_i);
        word_o  = bitrev24({green_s, red_s, blue_s});
    end

endmodule

// File: rtl/neopixel_frame_feeder.sv
// Host-writable pixel frame that is scaled, reordered and pushed over an Avalon-MM
// master into the one-wire transmitter, on commit or on a periodic refresh tick.
module neopixel_frame_feeder
    import neopixel_frame_feeder_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ     = 50_000_000,
    parameter int unsigned NUMBER_OF_NEOPIXEL = 35,
    parameter int unsigned REFRESH_HZ         = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic [7:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned REFRESH_CYCLES = CLOCK_SPEED_HZ / REFRESH_HZ;
    localparam int unsigned TimerW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned IdxW   = (NUMBER_OF_NEOPIXEL > 1) ? $clog2(NUMBER_OF_NEOPIXEL) : 1;
    localparam int unsigned PixEnd = 32'(PIXEL_BASE) + NUMBER_OF_NEOPIXEL;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(REFRESH_CYCLES - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUMBER_OF_NEOPIXEL - 1);

    feeder_state_e     state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              pending_q, pending_d;
    logic              auto_refresh_q, auto_refresh_d;
    logic [7:0]        bright_q, bright_d;
    logic [7:0]        frame_bright_q, frame_bright_d;
    logic [31:0]       frame_count_q, frame_count_d;
    logic [TimerW-1:0] timer_q, timer_d;

    color_t            mem_q [NUMBER_OF_NEOPIXEL];
    color_t            rd_q;
    logic [23:0]       pixel_word;

    logic              busy_int;
    logic              pix_sel;
    logic              pix_wr;
    logic [IdxW-1:0]   pix_idx;
    logic              ctrl_wr;
    logic              commit;
    logic              tick;
    logic              start;
    logic              unused_inputs;

    assign busy_int = (state_q != StIdle);
    assign busy     = busy_int;

    assign pix_sel = (s_address >= PIXEL_BASE) && (32'(s_address) < PixEnd);
    assign pix_idx = IdxW'(s_address - PIXEL_BASE);
    assign pix_wr  = s_write && pix_sel && !busy_int;
    assign ctrl_wr = s_write && (s_address == CTRL);
    assign commit  = ctrl_wr && s_writedata[0];
    assign tick    = (timer_q == TimerLast);
    assign start   = (state_q == StIdle) && (commit || pending_q || (tick && auto_refresh_q));

    // Pixel RAM stays frozen while a frame is being streamed out.
    assign s_waitrequest = s_write && pix_sel && busy_int;

    assign unused_inputs = ^{s_read, s_writedata[31:24]};

    always_ff @(posedge clock) begin
        if (pix_wr) begin
            mem_q[pix_idx] <= s_writedata[23:0];
        end
        if (state_q == StFetch) begin
            rd_q <= mem_q[idx_q];
        end
    end

    neopixel_pixel_scaler u_scaler (
        .rgb_i    (rd_q),
        .bright_i (frame_bright_q),
        .word_o   (pixel_word)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        m_write     = 1'b0;
        m_address   = 8'h00;
        m_writedata = 32'h0;
        frame_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWrite;
            end
            StWrite: begin
                m_write     = 1'b1;
                m_address   = TX_PIXEL_BASE + 8'(idx_q);
                m_writedata = {8'h00, pixel_word};
                if (!m_waitrequest) begin
                    if (idx_q == IdxLast) begin
                        state_d = StTrigger;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StTrigger: begin
                m_write     = 1'b1;
                m_address   = TX_TRIGGER;
                m_writedata = 32'd1;
                if (!m_waitrequest) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        pending_d      = pending_q;
        auto_refresh_d = auto_refresh_q;
        bright_d       = bright_q;
        frame_bright_d = frame_bright_q;
        frame_count_d  = frame_count_q + {31'd0, frame_done};
        timer_d        = tick ? '0 : timer_q + 1'b1;
        if (ctrl_wr) begin
            auto_refresh_d = s_writedata[1];
        end
        if (s_write && (s_address == BRIGHT)) begin
            bright_d = s_writedata[7:0];
        end
        // Any number of commits during a frame collapse into one follow-up frame.
        if (start) begin
            pending_d      = 1'b0;
            frame_bright_d = bright_q;
        end else if (commit && busy_int) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            auto_refresh_q <= 1'b0;
            bright_q       <= 8'hFF;
            frame_bright_q <= 8'hFF;
            frame_count_q  <= 32'h0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            auto_refresh_q <= auto_refresh_d;
            bright_q       <= bright_d;
            frame_bright_q <= frame_bright_d;
            frame_count_q  <= frame_count_d;
            timer_q        <= timer_d;
        end
    end

    // Pixel RAM has no host read path; pixel addresses read as unmapped.
    always_comb begin
        case (s_address)
            CTRL:    s_readdata = {29'd0, pending_q, auto_refresh_q, busy_int};
            BRIGHT:  s_readdata = {24'd0, bright_q};
            FCOUNT:  s_readdata = frame_count_q;
            default: s_readdata = READ_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_neopixel_frame_feeder.sv
// Randomized bench for neopixel_frame_feeder against a frame-level reference model.
module tb_neopixel_frame_feeder;

    localparam int unsigned N  = 35;
    localparam int unsigned RC = 200;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_BRIGHT = 8'h01;
    localparam logic [7:0] A_FCOUNT = 8'h02;
    localparam logic [7:0] A_PIX    = 8'h10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  s_address = 8'h00;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = 32'h0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [7:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        busy;
    logic        frame_done;

    always #5 clock = ~clock;

    neopixel_frame_feeder #(
        .CLOCK_SPEED_HZ     (6000),
        .NUMBER_OF_NEOPIXEL (N),
        .REFRESH_HZ         (30)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned cyc = 0;

    logic [23:0]  pix_m [N];
    logic [7:0]   bright_m = 8'hFF;
    int unsigned  fc_m = 0;
    logic [39:0]  acc_q [$];
    int unsigned  start_q [$];
    int unsigned  busy_cyc = 0;
    int unsigned  done_cnt = 0;
    int unsigned  stall4_cyc = 0;
    int           first_wr_cyc = -1;
    int unsigned  wr_cyc = 0;
    int unsigned  last_stalls = 0;
    logic         prev_busy = 1'b0;
    logic         stall_v = 1'b0;
    logic [7:0]   stall_a = 8'h00;
    logic [31:0]  stall_d = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pixel word: scale each channel arithmetically, order as G,R,B, mirror.
    function automatic logic [31:0] exp_word(input logic [23:0] p, input logic [7:0] b);
        int unsigned r, g, bl;
        logic [23:0] grb, rev;
        r   = (int'(p[23:16]) * (int'(b) + 1)) / 256;
        g   = (int'(p[15:8])  * (int'(b) + 1)) / 256;
        bl  = (int'(p[7:0])   * (int'(b) + 1)) / 256;
        grb = 24'((g << 16) | (r << 8) | bl);
        for (int i = 0; i < 24; i++) rev[i] = grb[23-i];
        return {8'h00, rev};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset_n) begin
            stall_v   <= 1'b0;
            prev_busy <= 1'b0;
        end else begin
            if (stall_v) begin
                check_eq("stall_hold_w", {31'd0, m_write}, 32'd1);
                check_eq("stall_hold_a", {24'd0, m_address}, {24'd0, stall_a});
                check_eq("stall_hold_d", m_writedata, stall_d);
            end
            stall_v <= m_write && m_waitrequest;
            stall_a <= m_address;
            stall_d <= m_writedata;
            if (m_write && !m_waitrequest) acc_q.push_back({m_address, m_writedata});
            if (m_write && m_waitrequest && m_address == 8'd4) stall4_cyc <= stall4_cyc + 1;
            if (m_write && first_wr_cyc < 0) first_wr_cyc <= int'(cyc);
            if (busy) busy_cyc <= busy_cyc + 1;
            if (busy && !prev_busy) start_q.push_back(cyc);
            prev_busy <= busy;
            if (frame_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        last_stalls = 0;
        @(posedge clock); #1;
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clock);
        while (s_waitrequest && last_stalls < 2000) begin
            last_stalls++;
            @(negedge clock);
        end
        if (s_waitrequest) check_eq("wr_timeout", {31'd0, s_waitrequest}, 32'd0);
        wr_cyc = cyc;
        if (int'(a) >= int'(A_PIX) && int'(a) < int'(A_PIX) + N) pix_m[a - A_PIX] = d[23:0];
        if (a == A_BRIGHT) bright_m = d[7:0];
        @(posedge clock); #1;
        s_write = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(posedge clock); #1;
        s_address = a; s_read = 1'b1;
        @(negedge clock);
        check_eq(tag, s_readdata, exp);
        @(posedge clock); #1;
        s_read = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input string tag);
        int unsigned n = 0;
        do begin
            @(posedge clock); #1;
            m_waitrequest = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clock);
            n++;
        end while (busy && n < 20000);
        m_waitrequest = 1'b0;
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frame(input logic [23:0] px [N], input logic [7:0] b);
        logic [39:0] e;
        for (int i = 0; i <= N; i++) begin
            if (acc_q.size() == 0) begin
                check_eq("frame_len", 32'(i), N + 1);
                return;
            end
            e = acc_q.pop_front();
            if (i < N) begin
                check_eq($sformatf("pix%0d_addr", i), {24'd0, e[39:32]}, 32'(i + 1));
                check_eq($sformatf("pix%0d_data", i), e[31:0], exp_word(px[i], b));
            end else begin
                check_eq("trig_addr", {24'd0, e[39:32]}, 32'd0);
                check_eq("trig_data", e[31:0], 32'd1);
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] snap_a [N];
        logic [23:0] snap_b [N];
        logic [7:0]  b1, b2;
        int unsigned n, nfr;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check_eq("rst_m_write", {31'd0, m_write}, 32'd0);
        check_eq("rst_m_addr", {24'd0, m_address}, 32'd0);
        check_eq("rst_m_data", m_writedata, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_swait", {31'd0, s_waitrequest}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check_rd("rd_ctrl", A_CTRL, 32'd0);
        check_rd("rd_bright", A_BRIGHT, 32'd255);
        check_rd("rd_fcount", A_FCOUNT, 32'd0);
        check_rd("rd_unmapped5", 8'h05, 32'hDEADBEEF);
        check_rd("rd_unmappedff", 8'hFF, 32'hDEADBEEF);

        // Load frame; the out-of-range pixel write must not alias into the RAM
        for (int i = 0; i < N; i++) host_write(A_PIX + 8'(i), $urandom);
        host_write(A_PIX, 32'hAB_FF8001);
        host_write(A_PIX + 8'(N), $urandom);

        // Full frame, no stall, latency and busy length
        acc_q.delete(); busy_cyc = 0; done_cnt = 0; first_wr_cyc = -1;
        host_write(A_CTRL, 32'd1);
        wait_idle(1'b0, "f1_idle");
        check_eq("f1_latency", 32'(first_wr_cyc), wr_cyc + 2);
        check_eq("f1_busy_cyc", busy_cyc, 2 * N + 1);
        check_eq("f1_done", done_cnt, 1);
        if (acc_q.size() > 0) check_eq("f1_pix0_const", acc_q[0][31:0], 32'h0080FF01);
        check_frame(pix_m, 8'd255);
        fc_m++;
        check_rd("f1_fcount", A_FCOUNT, fc_m);

        // Brightness 127
        host_write(A_BRIGHT, 32'd127);
        check_rd("rd_bright127", A_BRIGHT, 32'd127);
        acc_q.delete();
        host_write(A_CTRL, 32'd1);
        wait_idle(1'b0, "f2_idle");
        if (acc_q.size() > 0) check_eq("f2_pix0_const", acc_q[0][31:0], 32'h0000FE02);
        check_frame(pix_m, 8'd127);
        fc_m++;

        // Brightness sampling, repeated commits while busy, stalled pixel write
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        host_write(A_BRIGHT, {24'd0, b1});
        snap_a = pix_m;
        acc_q.delete(); done_cnt = 0;
        host_write(A_CTRL, 32'd1);
        host_write(A_BRIGHT, {24'd0, b2});
        check_eq("bright_busy_nostall", last_stalls, 0);
        repeat (3) host_write(A_CTRL, 32'd1);
        check_rd("ctrl_pending", A_CTRL, 32'd5);
        host_write(A_PIX + 8'd5, $urandom);
        check_eq("pix_busy_stall", {31'd0, last_stalls != 0}, 32'd1);
        snap_b = pix_m;
        wait_idle(1'b0, "fb_idle");
        repeat (30) @(posedge clock);
        check_eq("pend_done", done_cnt, 2);
        check_frame(snap_a, b1);
        check_frame(snap_b, b2);
        check_eq("pend_no_extra", acc_q.size(), 0);
        fc_m += 2;
        check_rd("pend_fcount", A_FCOUNT, fc_m);

        // Long stall on pixel 3 (address 4)
        acc_q.delete(); stall4_cyc = 0;
        host_write(A_CTRL, 32'd1);
        n = 0;
        @(negedge clock);
        while (!(m_write && !m_waitrequest && m_address == 8'd3) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("saw_addr3", {24'd0, m_address}, 32'd3);
        @(posedge clock); #1 m_waitrequest = 1'b1;
        repeat (101) @(posedge clock);
        #1 m_waitrequest = 1'b0;
        wait_idle(1'b0, "st_idle");
        check_eq("stall4_cycles", stall4_cyc, 100);
        check_frame(pix_m, bright_m);
        fc_m++;

        // Random frames under random transmitter stalls
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) host_write(A_PIX + 8'($urandom_range(0, N - 1)), $urandom);
            host_write(A_BRIGHT, $urandom);
            snap_a = pix_m;
            b1 = bright_m;
            acc_q.delete();
            host_write(A_CTRL, 32'd1);
            wait_idle(1'b1, "rs_idle");
            check_frame(snap_a, b1);
            fc_m++;
        end
        check_rd("rs_fcount", A_FCOUNT, fc_m);

        // Auto-refresh
        start_q.delete(); acc_q.delete(); done_cnt = 0;
        host_write(A_CTRL, 32'd2);
        repeat (700) @(posedge clock);
        n = 0;
        @(negedge clock);
        while (!busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        host_write(A_CTRL, 32'd0);
        wait_idle(1'b0, "ar_idle");
        nfr = start_q.size();
        check_eq("ar_frames", {31'd0, nfr >= 4}, 32'd1);
        for (int i = 0; i + 1 < int'(nfr); i++) check_eq("ar_gap", start_q[i+1] - start_q[i], RC);
        check_eq("ar_done", done_cnt, nfr);
        for (int i = 0; i < int'(nfr); i++) check_frame(pix_m, bright_m);
        fc_m += nfr;
        start_q.delete();
        repeat (450) @(posedge clock);
        check_eq("ar_stopped", start_q.size(), 0);
        check_rd("ar_fcount", A_FCOUNT, fc_m);

        // Reset in the middle of pixel 10
        host_write(A_BRIGHT, 32'd50);
        host_write(A_CTRL, 32'd3);
        host_write(A_CTRL, 32'd3);
        n = 0;
        @(negedge clock);
        while (!(m_write && m_address == 8'd11) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("saw_addr11", {24'd0, m_address}, 32'd11);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_m_write", {31'd0, m_write}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        s_address = A_CTRL;   #1 check_eq("mid_rst_ctrl", s_readdata, 32'd0);
        s_address = A_BRIGHT; #1 check_eq("mid_rst_bright", s_readdata, 32'd255);
        s_address = A_FCOUNT; #1 check_eq("mid_rst_fcount", s_readdata, 32'd0);
        bright_m = 8'hFF;
        fc_m = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        acc_q.delete(); start_q.delete(); done_cnt = 0;
        host_write(A_CTRL, 32'd1);
        wait_idle(1'b0, "pr_idle");
        check_frame(pix_m, 8'd255);
        fc_m++;
        repeat (450) @(posedge clock);
        check_eq("pr_no_extra", acc_q.size(), 0);
        check_eq("pr_starts", start_q.size(), 1);
        check_rd("pr_fcount", A_FCOUNT, fc_m);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
